// File: rtl/srlzr_deserializer_if.sv
// Bundle of the serial-in and parallel-out signals of srlzr_deserializer.
// Serial side: sin, bit_en, sync. Parallel side: y/y_valid/y_ready handshake.
// Status side: busy, frame_err, overrun, ovr_clr. "slave" is the deserializer's view.
interface srlzr_deserializer_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  sin;
  logic                  bit_en;
  logic                  sync;
  logic [DATA_WIDTH-1:0] y;
  logic                  y_valid;
  logic                  y_ready;
  logic                  busy;
  logic                  frame_err;
  logic                  overrun;
  logic                  ovr_clr;

  modport master (
    output sin, bit_en, sync, y_ready, ovr_clr,
    input  y, y_valid, busy, frame_err, overrun
  );

  modport slave (
    input  sin, bit_en, sync, y_ready, ovr_clr,
    output y, y_valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/srlzr_deserializer.sv
// Purpose: collects MSB-first serial bits (qualified by bit_en, framed by sync) into words.
// Latency: a word is on y with y_valid=1 one cycle after its last bit_en.
// Backpressure: y holds until y_ready; a word finishing while y is unconsumed is dropped and overrun is set.
// Ports: clk, rst_n (active-high async reset), bus (srlzr_deserializer_if.slave).
module srlzr_deserializer #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  srlzr_deserializer_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [CW-1:0]         count_q, count_nxt;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_done;
  logic                  abort;

  logic [DATA_WIDTH-1:0] y_q;
  logic                  y_valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    count_nxt = count_q;
    word_done = 1'b0;
    abort     = 1'b0;
    word      = {shift_q[DATA_WIDTH-2:0], bus.sin};
    case (state_q)
      IDLE: begin
        // Bits without a preceding sync are noise and are dropped here.
        if (bus.bit_en && bus.sync) begin
          shift_nxt = {{(DATA_WIDTH-1){1'b0}}, bus.sin};
          count_nxt = CW'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (bus.bit_en) begin
          if (bus.sync) begin
            // Resynchronise: this bit becomes the MSB of a fresh word.
            abort     = 1'b1;
            shift_nxt = {{(DATA_WIDTH-1){1'b0}}, bus.sin};
            count_nxt = CW'(1);
          end else if (count_q == CW'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            shift_nxt = word;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            shift_nxt = word;
            count_nxt = count_q + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= abort;
      // A consumer accepting on the completing edge frees y for the new word.
      if (word_done && (!y_valid_q || bus.y_ready)) begin
        y_q       <= word;
        y_valid_q <= 1'b1;
      end else if (y_valid_q && bus.y_ready) begin
        y_valid_q <= 1'b0;
      end
      // Set has priority over clear so a drop is never lost.
      if (word_done && y_valid_q && !bus.y_ready) begin
        overrun_q <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.busy      = (state_q == RECV);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_srlzr_deserializer.sv
module tb_srlzr_deserializer;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  srlzr_deserializer_if #(.DATA_WIDTH(DW)) bus ();

  srlzr_deserializer #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the partial word is a list of received bits; a word exists
  // only once that list reaches DW entries after a sync-marked first bit.
  bit            partial[$];
  logic [DW-1:0] m_y    = '0;
  logic          m_vld  = 1'b0;
  logic          m_ferr = 1'b0;
  logic          m_ovr  = 1'b0;
  logic          m_done;
  logic          m_drop;
  logic [DW-1:0] m_w;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      partial.delete();
      m_y = '0; m_vld = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_drop = 1'b0;
      m_ferr = 1'b0;
      m_w    = '0;
      if (bus.bit_en) begin
        if (bus.sync) begin
          if (partial.size() > 0) m_ferr = 1'b1;
          partial.delete();
          partial.push_back(bus.sin);
        end else if (partial.size() > 0) begin
          partial.push_back(bus.sin);
          if (partial.size() == DW) begin
            foreach (partial[i]) m_w = (m_w << 1) | DW'(partial[i]);
            m_done = 1'b1;
            partial.delete();
          end
        end
      end
      if (m_done) begin
        if (!m_vld || bus.y_ready) begin
          m_y   = m_w;
          m_vld = 1'b1;
        end else begin
          m_drop = 1'b1;
        end
      end else if (m_vld && bus.y_ready) begin
        m_vld = 1'b0;
      end
      if (m_drop) m_ovr = 1'b1;
      else if (bus.ovr_clr) m_ovr = 1'b0;
    end
  end

  // Every-cycle comparison against the reference.
  always @(posedge clk) begin
    #1;
    chk("model_y",         32'(bus.y),     32'(m_y));
    chk("model_y_valid",   32'(bus.y_valid), 32'(m_vld));
    chk("model_busy",      32'(bus.busy),  32'(partial.size() != 0));
    chk("model_frame_err", 32'(bus.frame_err), 32'(m_ferr));
    chk("model_overrun",   32'(bus.overrun), 32'(m_ovr));
  end

  task automatic tick(input logic en, input logic s, input logic b,
                      input logic rdy, input logic clr);
    @(negedge clk);
    bus.bit_en  = en;
    bus.sync    = s;
    bus.sin     = b;
    bus.y_ready = rdy;
    bus.ovr_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int bc;
    bus.sin = 1'b0; bus.bit_en = 1'b0; bus.sync = 1'b0;
    bus.y_ready = 1'b0; bus.ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_y", 32'(bus.y), 0);
    chk("reset_valid", 32'(bus.y_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_overrun", 32'(bus.overrun), 0);
    rst_n = 1'b0;

    // Basic word 1011.
    bc = 0;
    tick(1, 1, 1, 1, 0); bc += int'(bus.busy);
    tick(1, 0, 0, 1, 0); bc += int'(bus.busy);
    tick(1, 0, 1, 1, 0); bc += int'(bus.busy);
    tick(1, 0, 1, 1, 0); bc += int'(bus.busy);
    chk("basic_y", 32'(bus.y), 32'hB);
    chk("basic_valid", 32'(bus.y_valid), 1);
    tick(0, 0, 0, 1, 0); bc += int'(bus.busy);
    chk("basic_valid_drop", 32'(bus.y_valid), 0);
    chk("basic_busy_cycles", 32'(bc), 3);

    // Gapped bits.
    tick(1, 1, 1, 1, 0);
    tick(0, 0, 0, 1, 0); tick(0, 0, 1, 1, 0);
    chk("gap_busy", 32'(bus.busy), 1);
    tick(1, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 0);
    tick(1, 0, 1, 1, 0);
    tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 0);
    chk("gap_busy2", 32'(bus.busy), 1);
    tick(1, 0, 1, 1, 0);
    chk("gap_y", 32'(bus.y), 32'hB);
    chk("gap_valid", 32'(bus.y_valid), 1);
    tick(0, 0, 0, 1, 0);

    // Realign: 1,0 then sync on 0,1,1,0.
    tick(1, 1, 1, 1, 0);
    tick(1, 0, 0, 1, 0);
    tick(1, 1, 0, 1, 0);
    chk("realign_ferr", 32'(bus.frame_err), 1);
    tick(1, 0, 1, 1, 0);
    chk("realign_ferr_pulse", 32'(bus.frame_err), 0);
    tick(1, 0, 1, 1, 0);
    tick(1, 0, 0, 1, 0);
    chk("realign_y", 32'(bus.y), 32'h6);
    chk("realign_valid", 32'(bus.y_valid), 1);
    chk("realign_ovr", 32'(bus.overrun), 0);
    tick(0, 0, 0, 1, 0);

    // Backpressure: A then 5 with y_ready low.
    tick(1, 1, 1, 0, 0); tick(1, 0, 0, 0, 0); tick(1, 0, 1, 0, 0); tick(1, 0, 0, 0, 0);
    chk("bp_first_y", 32'(bus.y), 32'hA);
    tick(1, 1, 0, 0, 0); tick(1, 0, 1, 0, 0); tick(1, 0, 0, 0, 0); tick(1, 0, 1, 0, 0);
    chk("bp_y_held", 32'(bus.y), 32'hA);
    chk("bp_overrun", 32'(bus.overrun), 1);
    chk("bp_valid", 32'(bus.y_valid), 1);
    tick(0, 0, 0, 0, 1);
    chk("bp_ovr_clr", 32'(bus.overrun), 0);

    // Simultaneous accept: A pending, 3 completes with y_ready=1.
    tick(1, 1, 0, 0, 0); tick(1, 0, 0, 0, 0); tick(1, 0, 1, 0, 0); tick(1, 0, 1, 1, 0);
    chk("sim_y", 32'(bus.y), 32'h3);
    chk("sim_valid", 32'(bus.y_valid), 1);
    chk("sim_ovr", 32'(bus.overrun), 0);
    tick(0, 0, 0, 1, 0);
    chk("sim_consumed", 32'(bus.y_valid), 0);

    // Reset mid-word, asserted away from a clock edge.
    tick(1, 1, 1, 0, 0); tick(1, 0, 1, 0, 0);
    chk("rst_pre_busy", 32'(bus.busy), 1);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_async_y", 32'(bus.y), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    chk("rst_async_valid", 32'(bus.y_valid), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    tick(1, 0, 1, 1, 0);
    chk("rst_stray_busy", 32'(bus.busy), 0);
    tick(1, 1, 1, 1, 0); tick(1, 0, 1, 1, 0); tick(1, 0, 0, 1, 0); tick(1, 0, 0, 1, 0);
    chk("rst_after_y", 32'(bus.y), 32'hC);
    chk("rst_after_valid", 32'(bus.y_valid), 1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(0, 199) == 0);
      bus.bit_en  = ($urandom_range(0, 9) < 6);
      bus.sync    = ($urandom_range(0, 9) == 0);
      bus.sin     = 1'($urandom_range(0, 1));
      bus.y_ready = 1'($urandom_range(0, 1));
      bus.ovr_clr = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus.bit_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/srlzr_deserializer.md
SRLZR_DESERIALIZER -- requirements
Module: srlzr_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, parallel word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-high reset (the name is kept for consistency with the serializer; the polarity is high).
REQ-004 SHALL have port sin  input  1  serial data in; MSB of the word arrives first, matching the serializer's output order.
REQ-005 SHALL have port bit_en  input  1  qualifies sin; a bit is sampled only on an edge where bit_en=1.
REQ-006 SHALL have port sync  input  1  start-of-word marker; asserted together with bit_en on the first (MSB) bit.
REQ-007 SHALL have port y  output  DATA_WIDTH  received parallel word.
REQ-008 SHALL have port y_valid  output  1  y holds an unconsumed word.
REQ-009 SHALL have port y_ready  input  1  consumer accepts y when y_valid=1 and y_ready=1.
REQ-010 SHALL have port busy  output  1  a word is partially received (the FSM is in RECV).
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a partial word is aborted by sync.
REQ-012 SHALL have port overrun  output  1  sticky flag set when a completed word is dropped.
REQ-013 SHALL have port ovr_clr  input  1  synchronous clear of overrun.

Function
REQ-014 SHALL implement a two-state FSM (IDLE, RECV), a DATA_WIDTH-bit shift register, a bit counter of ceil(log2(DATA_WIDTH+1)) bits, and a separate output register y.
REQ-015 IDLE: bit_en=1 and sync=1 SHALL load sin into the shift register LSB, set count=1, and go to RECV.
REQ-016 IDLE: bit_en=1 with sync=0 SHALL be ignored; there is no state change and no flag.
REQ-017 RECV: bit_en=1 and sync=0 SHALL shift left, insert sin at the LSB, and increment count.
REQ-018 RECV: when the sampled bit makes count reach DATA_WIDTH, the FSM SHALL build the word {shift[DATA_WIDTH-2:0], sin}, return to IDLE, and clear count to 0.
REQ-019 A completed word SHALL appear on y with y_valid=1 on the edge that samples its last bit; y_valid is observed high the cycle after that bit's bit_en.
REQ-020 RECV: bit_en=1 and sync=1 SHALL discard the partial word, pulse frame_err for one cycle, and restart with that bit as MSB (count=1, stay in RECV).
REQ-021 bit_en=0 SHALL hold the FSM, count, and shift register unchanged, including between the bits of a word.
REQ-022 The y/y_valid handshake SHALL follow these rules:
- y_valid stays high and y stays stable until y_ready=1.
- On acceptance with no new word completing, y_valid drops on the next edge.
REQ-023 If a word completes on the same edge as an acceptance (y_valid=1, y_ready=1), the new word SHALL load into y, y_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-024 If a word completes while y_valid=1 and y_ready=0, the new word SHALL be dropped, y SHALL be unchanged, and overrun SHALL be set.
REQ-025 overrun SHALL clear on the edge where ovr_clr=1; if a set condition occurs on the same edge, set SHALL win.
REQ-026 busy SHALL be 1 exactly while the FSM is in RECV.
REQ-027 The serial path SHALL have no combinational path from any input to any output; all outputs are registered.

Reset
REQ-028 When rst_n=1, independent of clk, the block SHALL force:
- FSM to IDLE, count=0, shift register=0;
- y=0, y_valid=0, busy=0, frame_err=0, overrun=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word; after release, the first bit accepted is the next sync-marked bit.
REQ-030 Release of rst_n SHALL take effect cleanly at the next clk edge; no bit is sampled while rst_n=1.

Verification (DATA_WIDTH=4)
REQ-031 Basic word: sync+bit_en on bits 1,0,1,1 over 4 consecutive cycles, y_ready=1 -> y=4'b1011, y_valid high for 1 cycle after the 4th bit, busy high for 3 cycles.
REQ-032 Gapped bits: the same word with bit_en low for 2 cycles between each bit -> y=4'b1011; busy stays high through the gaps.
REQ-033 Realign: send 1,0 then sync on new bits 0,1,1,0 -> frame_err pulses once, y=4'b0110, no other flag.
REQ-034 Backpressure: y_ready=0, send 4'hA then 4'h5 -> y stays 4'hA, overrun=1; ovr_clr pulse -> overrun=0.
REQ-035 Simultaneous accept: y=4'hA pending; y_ready=1 on the edge the last bit of 4'h3 is sampled -> y=4'h3, y_valid stays 1, overrun=0.
REQ-036 Reset mid-word: assert rst_n after 2 bits -> all outputs 0 asynchronously; a stray bit_en without sync after release is ignored; the next synced word 4'hC is received correctly.
